// File: rtl/urv_dbg_host.sv
// urv_dbg_host: host-side sequencer for the uRV fetch-stage debug port.
// Buffers injected instructions and paces them against the core's halt/drain handshake.
module urv_dbg_host #(
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT      = 1024,
  parameter bit START_HALTED = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [31:0] cmd_insn_i,
  output logic        halted_o,
  output logic        busy_o,
  output logic        err_timeout_o,
  output logic [15:0] insn_count_o,
  output logic        dbg_force_o,
  input  logic        dbg_enabled_i,
  output logic [31:0] dbg_insn_o,
  output logic        dbg_insn_set_o,
  input  logic        dbg_insn_ready_i
);

  localparam int          AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] TMO_LIMIT  = 16'(TIMEOUT);
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] EBREAK     = 32'h0010_0073;

  localparam logic [1:0] OP_CLRERR = 2'd0;
  localparam logic [1:0] OP_HALT   = 2'd1;
  localparam logic [1:0] OP_EXEC   = 2'd2;
  localparam logic [1:0] OP_RESUME = 2'd3;

  typedef enum logic [2:0] {
    S_RUN,
    S_HALT_REQ,
    S_HALTED,
    S_ISSUE,
    S_DRAIN,
    S_RESUME_WAIT
  } state_t;

  localparam state_t RESET_STATE = START_HALTED ? S_HALT_REQ : S_RUN;

  state_t        state, state_next;
  logic [32:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          accept, push, pop, is_halt, is_clrerr;
  logic [32:0]   push_data, head;
  logic          issue_resume, drain_first;
  logic [15:0]   tmo_cnt, tmo_next;
  logic          counting, tmo_hit;

  assign accept    = cmd_valid_i && cmd_ready_o;
  assign push      = accept && (cmd_op_i == OP_EXEC || cmd_op_i == OP_RESUME);
  assign is_halt   = accept && (cmd_op_i == OP_HALT);
  assign is_clrerr = accept && (cmd_op_i == OP_CLRERR);
  assign push_data = (cmd_op_i == OP_RESUME) ? {1'b1, EBREAK} : {1'b0, cmd_insn_i};
  assign head      = fifo_mem[rd_ptr];

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      S_RUN:         if (is_halt) state_next = S_HALT_REQ;
      S_HALT_REQ:    if (dbg_enabled_i) state_next = S_HALTED;
      S_HALTED: begin
        if (count != '0 && dbg_enabled_i && dbg_insn_ready_i) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE:       state_next = issue_resume ? S_RESUME_WAIT : S_DRAIN;
      // Core ready lags the issue strobe by a cycle, so the first drain cycle is blind.
      S_DRAIN:       if (!drain_first && dbg_insn_ready_i) state_next = S_HALTED;
      S_RESUME_WAIT: if (!dbg_enabled_i) state_next = S_RUN;
      default:       state_next = S_RUN;
    endcase
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Only the transition onto the limit raises the flag, so CLRERR sticks while saturated.
  always_comb begin
    counting = (state == S_HALT_REQ) || (state == S_DRAIN) || (state == S_RESUME_WAIT);
    tmo_next = tmo_cnt;
    if (state_next != state) tmo_next = '0;
    else if (counting && tmo_cnt != TMO_LIMIT) tmo_next = tmo_cnt + 16'd1;
    tmo_hit = (tmo_cnt != TMO_LIMIT) && (tmo_next == TMO_LIMIT);
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= RESET_STATE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      tmo_cnt        <= '0;
      issue_resume   <= 1'b0;
      drain_first    <= 1'b0;
      dbg_force_o    <= START_HALTED;
      dbg_insn_o     <= NOP;
      dbg_insn_set_o <= 1'b0;
      err_timeout_o  <= 1'b0;
      insn_count_o   <= '0;
      cmd_ready_o    <= 1'b1;
      halted_o       <= 1'b0;
      busy_o         <= START_HALTED;
    end else begin
      state        <= state_next;
      count        <= count_next;
      tmo_cnt      <= tmo_next;
      issue_resume <= pop && head[32];
      drain_first  <= (state_next == S_DRAIN) && (state != S_DRAIN);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      dbg_insn_set_o <= pop;
      dbg_insn_o     <= pop ? head[31:0] : NOP;
      if (pop && !head[32]) insn_count_o <= insn_count_o + 16'd1;

      if (pop && head[32]) dbg_force_o <= 1'b0;
      if (is_halt)         dbg_force_o <= 1'b1;

      if (is_clrerr) err_timeout_o <= 1'b0;
      if (tmo_hit)   err_timeout_o <= 1'b1;

      cmd_ready_o <= (count_next != FULL_COUNT);
      halted_o    <= (state_next == S_HALTED) && (count_next == '0);
      busy_o      <= !(state_next == S_RUN || state_next == S_HALTED) || (count_next != '0);
    end
  end

endmodule

// File: doc/urv_dbg_host.md
# urv_dbg_host

Host-side driver for the uRV fetch-stage debug port. It accepts halt, execute-instruction and resume commands from a debug transport (JTAG/UART bridge) and buffers injected instruction words in a small FIFO. It sequences `dbg_force`, `dbg_insn`, `dbg_insn_set` against the core's `dbg_enabled` and `dbg_insn_ready`, so the host never has to track pipeline drain timing. It sits between the debug transport and `urv_cpu`'s debug inputs.

## Interface
- `FIFO_DEPTH`, 4: instruction FIFO entries (power of two, ≥2).
- `TIMEOUT`, 1024: cycles waited for a core response before flagging `err_timeout_o`.
- `START_HALTED`, 0: if 1, `dbg_force_o` is high out of reset so the core boots into debug mode.

Ports:
- `clk_i` in 1: core clock.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `cmd_valid_i` in 1: command strobe.
- `cmd_ready_o` out 1: command accepted when `cmd_valid_i && cmd_ready_o`.
- `cmd_op_i` in 2: opcode. 0=CLRERR, 1=HALT, 2=EXEC, 3=RESUME.
- `cmd_insn_i` in 32: instruction word for EXEC.
- `halted_o` out 1: FSM in HALTED with an empty FIFO.
- `busy_o` out 1: FSM not in RUN or HALTED, or FIFO not empty.
- `err_timeout_o` out 1: sticky timeout flag.
- `insn_count_o` out 16: count of issued EXEC instructions; wraps.
- `dbg_force_o` out 1: debug-mode request to fetch.
- `dbg_enabled_i` in 1: core is in debug mode.
- `dbg_insn_o` out 32: injected instruction.
- `dbg_insn_set_o` out 1: one-cycle strobe; `dbg_insn_o` is new.
- `dbg_insn_ready_i` in 1: core pipeline drained; ready for the next instruction.

## Operation
- FIFO entries are 33 bits: {resume flag, insn}.
  - EXEC pushes {0, `cmd_insn_i`}.
  - RESUME pushes {1, 0x00100073} (EBREAK).
- `cmd_ready_o` = FIFO not full. HALT and CLRERR do not need FIFO space but use the same ready, so the handshake stays uniform.
- CLRERR: clears `err_timeout_o`.
- HALT: sets `dbg_force_o`. In RUN it moves the FSM to HALT_REQ; in any other state it is a no-op apart from `dbg_force_o`.
- States:
  - RUN: `dbg_force_o`=0. HALT → HALT_REQ. Queued EXEC entries stay queued.
  - HALT_REQ: `dbg_force_o`=1. Waits for `dbg_enabled_i`=1, then → HALTED.
  - HALTED: when FIFO non-empty && `dbg_enabled_i` && `dbg_insn_ready_i`: pop, load outputs, → ISSUE.
  - ISSUE (exactly 1 cycle): `dbg_insn_set_o`=1, `dbg_insn_o`=entry insn.
    - Resume entry: `dbg_force_o`←0 in this same cycle, → RESUME_WAIT.
    - Otherwise: increment `insn_count_o`, → DRAIN.
  - DRAIN: ignores `dbg_insn_ready_i` in its first cycle (core ready lags by one cycle). Afterwards, `dbg_insn_ready_i`=1 → HALTED.
  - RESUME_WAIT: `dbg_enabled_i`=0 → RUN.
- Outside ISSUE: `dbg_insn_o` = 0x00000013 (NOP). The fetch stage samples this port every debug cycle, so it must always carry a harmless instruction.
- Timeout: a 16-bit counter clears on every state change and counts while in HALT_REQ, DRAIN or RESUME_WAIT. Reaching `TIMEOUT` sets `err_timeout_o`. The FSM does not abort; the counter saturates.
- Simultaneous events:
  - Command accepted in the same cycle as a pop: push and pop both occur; FIFO occupancy is unchanged.
  - HALT during RESUME_WAIT: `dbg_force_o` reasserts. The FSM goes to RUN when `dbg_enabled_i` drops, then immediately to HALT_REQ on the next HALT.
  - Only an explicit HALT re-halts; a pending `dbg_force_o` alone does not move RUN → HALT_REQ. The transport must reissue HALT.
- Reset mid-operation: the FIFO empties and the FSM and all outputs return to reset values. Any in-flight instruction is discarded.

## Timing
- All outputs are registered. Reset values:
  - `dbg_force_o` = `START_HALTED`; state = HALT_REQ if `START_HALTED`, else RUN.
  - `dbg_insn_o` = 0x00000013.
  - `dbg_insn_set_o`, `err_timeout_o`, `insn_count_o` = 0.
  - `cmd_ready_o` = 1; `halted_o` = 0; `busy_o` = `START_HALTED`.
- HALT accepted at cycle N: `dbg_force_o`=1 at N+1.
- EXEC into an empty FIFO while HALTED and ready, accepted at N: `dbg_insn_set_o`=1 at N+2 (N+1 push visible, N+2 issue).
- Issue-to-issue minimum spacing is 6 cycles with the fetch stage's 4-cycle drain: ISSUE, DRAIN ×4, HALTED.
- Precondition: the core does not stall fetch while `dbg_insn_ready_i`=1.

## Test plan
- Halt: HALT at cycle 10 with the core model raising `dbg_enabled_i` 6 cycles later → `dbg_force_o`=1 at 11; `halted_o`=1 one cycle after `dbg_enabled_i`.
- Exec burst: halted; push EXEC 0x00500093, 0x00A00113, 0x002081B3 back-to-back → three single-cycle `dbg_insn_set_o` pulses in order, each after `dbg_insn_ready_i` re-rises, with NOP between; `insn_count_o`=3.
- FIFO full: core held not-ready; push 5 EXEC with `FIFO_DEPTH`=4 → `cmd_ready_o`=0 after the 4th; the 5th is accepted after the first issue.
- Resume: halted, RESUME → `dbg_insn_o`=0x00100073 with set=1, `dbg_force_o`=0 in the same cycle; RUN once `dbg_enabled_i` falls; `insn_count_o` unchanged.
- Timeout: HALT with `dbg_enabled_i` stuck 0, `TIMEOUT`=16 → `err_timeout_o`=1 at 16 cycles after entering HALT_REQ; CLRERR → 0 next cycle.
- Reset mid-DRAIN with 2 entries queued → next cycle: FIFO empty, RUN, `dbg_insn_set_o`=0, `dbg_insn_o`=0x00000013.
